reg_file_2r1w: RTL and testbench

- Parametrised successor to the team's plain 16-bit reset/clk/d/q register: an array of DEPTH registers, each WIDTH bits wide.
- One write port with byte enables and two read ports. Read data is registered, so a read takes one clock.
- Adds features the single register lacks: a synchronous clear-all, optional write-to-read bypass, an optional hardwired-zero entry 0, and read-hold enables.
- Used as a small scratch/working register bank in datapath blocks.

---
 rtl/reg_file_2r1w.sv | 140 ++++++++++++++
 tb/tb_reg_file_2r1w.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/reg_file_2r1w.sv
// Purpose : DEPTH x WIDTH register bank, one byte-enabled write port, two registered read ports.
// Latency : read data appears 1 clk after re; write visible same cycle (BYPASS=1) or next cycle (BYPASS=0).
// Backpr. : none; every port accepts a request on every cycle.
//
// Ports:
//   clk, reset        single rising-edge clock, synchronous active-high reset
//   clr               synchronous clear of every entry (reads issued that edge load 0)
//   we/waddr/wdata/wbe  write port; wbe[i] gates byte lane i
//   re0/ra0 -> rd0    read port 0; rd0 holds while re0 is low
//   re1/ra1 -> rd1    read port 1; rd1 holds while re1 is low
module reg_file_2r1w #(
  parameter int WIDTH    = 16,
  parameter int DEPTH    = 8,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 0,
  localparam int AW      = $clog2(DEPTH),
  localparam int NB      = WIDTH / 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [NB-1:0]    wbe,
  input  logic             re0,
  input  logic [AW-1:0]    ra0,
  output logic [WIDTH-1:0] rd0,
  input  logic             re1,
  input  logic [AW-1:0]    ra1,
  output logic [WIDTH-1:0] rd1
);

  // Elaboration-time parameter sanity.
  if ((WIDTH % 8) != 0 || WIDTH < 8) begin : g_bad_width
    $error("reg_file_2r1w: WIDTH must be a non-zero multiple of 8");
  end
  if (DEPTH < 2) begin : g_bad_depth
    $error("reg_file_2r1w: DEPTH must be >= 2");
  end

  // One extra bit so DEPTH itself is representable when DEPTH is a power of 2.
  localparam logic [AW:0] DEPTH_W = DEPTH[AW:0];

  // Addresses >= DEPTH only exist when DEPTH is not a power of 2.
  function automatic logic in_range(input logic [AW-1:0] a);
    return ({1'b0, a} < DEPTH_W);
  endfunction

  // Entry 0 is hardwired to zero when ZERO_REG is set.
  function automatic logic is_zero_entry(input logic [AW-1:0] a);
    return (ZERO_REG != 0) && (a == '0);
  endfunction

  // An address that maps onto real, writable storage.
  function automatic logic is_backed(input logic [AW-1:0] a);
    return in_range(a) && !is_zero_entry(a);
  endfunction

  logic [WIDTH-1:0] mem [DEPTH];

  // ---------------------------------------------------------------------------
  // Write path: merge the enabled byte lanes over the current entry contents.
  // The merged word is used both for the array update and for read bypass, so
  // a partial write forwards new bytes where wbe=1 and old bytes elsewhere.
  // ---------------------------------------------------------------------------
  logic             wr_ok;
  logic [WIDTH-1:0] wr_old;
  logic [WIDTH-1:0] wr_merged;

  always_comb begin
    wr_ok     = we && (wbe != '0) && is_backed(waddr);
    wr_old    = in_range(waddr) ? mem[waddr] : '0;
    wr_merged = wr_old;
    for (int i = 0; i < NB; i++) begin
      if (wbe[i]) begin
        wr_merged[8*i +: 8] = wdata[8*i +: 8];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Read path: both ports share one lookup structure, indexed by port number.
  // ---------------------------------------------------------------------------
  logic [1:0]       re_v;
  logic [AW-1:0]    ra_v   [2];
  logic [WIDTH-1:0] rd_nxt [2];
  logic [WIDTH-1:0] rd_q   [2];

  always_comb begin
    re_v    = {re1, re0};
    ra_v[0] = ra0;
    ra_v[1] = ra1;
    for (int p = 0; p < 2; p++) begin
      rd_nxt[p] = '0;
      if (!is_backed(ra_v[p])) begin
        // Out-of-range and hardwired-zero addresses read 0; a write to
        // them was dropped, so there is nothing to forward either.
        rd_nxt[p] = '0;
      end else if ((BYPASS != 0) && wr_ok && (ra_v[p] == waddr)) begin
        rd_nxt[p] = wr_merged;
      end else begin
        rd_nxt[p] = mem[ra_v[p]];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // State update. Priority: reset > clr > write. Reset also zeroes the read
  // registers and ignores re; clr still lets enabled reads load, but with 0,
  // so a clear is always seen immediately regardless of BYPASS.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int e = 0; e < DEPTH; e++) begin
        mem[e] <= '0;
      end
      for (int p = 0; p < 2; p++) begin
        rd_q[p] <= '0;
      end
    end else begin
      if (clr) begin
        for (int e = 0; e < DEPTH; e++) begin
          mem[e] <= '0;
        end
      end else if (wr_ok) begin
        mem[waddr] <= wr_merged;
      end
      for (int p = 0; p < 2; p++) begin
        if (re_v[p]) begin
          rd_q[p] <= clr ? '0 : rd_nxt[p];
        end
      end
    end
  end

  assign rd0 = rd_q[0];
  assign rd1 = rd_q[1];

endmodule

// File: tb/tb_reg_file_2r1w.sv
module tb_reg_file_2r1w;

  logic        clk;
  logic        reset;
  logic        clr;
  logic        we;
  logic [2:0]  waddr;
  logic [15:0] wdata;
  logic [1:0]  wbe;
  logic        re0;
  logic [2:0]  ra0;
  logic        re1;
  logic [2:0]  ra1;

  logic [15:0] rd0_m,  rd1_m;   // default: BYPASS=1, DEPTH=8
  logic [15:0] rd0_b0, rd1_b0;  // BYPASS=0
  logic [15:0] rd0_z,  rd1_z;   // ZERO_REG=1
  logic [15:0] rd0_d6, rd1_d6;  // DEPTH=6

  int checks;
  int errors;

  reg_file_2r1w #(.WIDTH(16), .DEPTH(8), .BYPASS(1), .ZERO_REG(0)) u_main (
    .clk(clk), .reset(reset), .clr(clr), .we(we), .waddr(waddr), .wdata(wdata), .wbe(wbe),
    .re0(re0), .ra0(ra0), .rd0(rd0_m), .re1(re1), .ra1(ra1), .rd1(rd1_m));

  reg_file_2r1w #(.WIDTH(16), .DEPTH(8), .BYPASS(0), .ZERO_REG(0)) u_nobyp (
    .clk(clk), .reset(reset), .clr(clr), .we(we), .waddr(waddr), .wdata(wdata), .wbe(wbe),
    .re0(re0), .ra0(ra0), .rd0(rd0_b0), .re1(re1), .ra1(ra1), .rd1(rd1_b0));

  reg_file_2r1w #(.WIDTH(16), .DEPTH(8), .BYPASS(1), .ZERO_REG(1)) u_zero (
    .clk(clk), .reset(reset), .clr(clr), .we(we), .waddr(waddr), .wdata(wdata), .wbe(wbe),
    .re0(re0), .ra0(ra0), .rd0(rd0_z), .re1(re1), .ra1(ra1), .rd1(rd1_z));

  reg_file_2r1w #(.WIDTH(16), .DEPTH(6), .BYPASS(1), .ZERO_REG(0)) u_d6 (
    .clk(clk), .reset(reset), .clr(clr), .we(we), .waddr(waddr), .wdata(wdata), .wbe(wbe),
    .re0(re0), .ra0(ra0), .rd0(rd0_d6), .re1(re1), .ra1(ra1), .rd1(rd1_d6));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    // Pre-load every entry with a distinct value.
    for (int a = 0; a < 8; a++) begin
      we = 1'b1; waddr = 3'(a); wdata = 16'(16'h1111 * (a + 1)); wbe = 2'b11;
      step();
    end
    we = 1'b0;
    re0 = 1'b1; ra0 = 3'd1; re1 = 1'b1; ra1 = 3'd2;
    step();
    checks++; if (rd0_m !== 16'h2222) begin errors++; $display("FAIL prewrite_rd0 got %h exp %h", rd0_m, 16'h2222); end
    checks++; if (rd1_m !== 16'h3333) begin errors++; $display("FAIL prewrite_rd1 got %h exp %h", rd1_m, 16'h3333); end
    // Reset with a concurrent write: the write must be lost.
    reset = 1'b1; we = 1'b1; waddr = 3'd4; wdata = 16'hFFFF; wbe = 2'b11;
    step();
    reset = 1'b0; we = 1'b0;
    checks++; if (rd0_m !== 16'h0000) begin errors++; $display("FAIL reset_rd0 got %h exp %h", rd0_m, 16'h0000); end
    checks++; if (rd1_m !== 16'h0000) begin errors++; $display("FAIL reset_rd1 got %h exp %h", rd1_m, 16'h0000); end
    checks++; if (rd0_d6 !== 16'h0000) begin errors++; $display("FAIL reset_d6_rd0 got %h exp %h", rd0_d6, 16'h0000); end
    for (int a = 0; a < 8; a++) begin
      re0 = 1'b1; ra0 = 3'(a); re1 = 1'b1; ra1 = 3'(7 - a);
      step();
      checks++; if (rd0_m !== 16'h0000) begin errors++; $display("FAIL reset_scan_rd0 addr %0d got %h exp %h", a, rd0_m, 16'h0000); end
      checks++; if (rd1_m !== 16'h0000) begin errors++; $display("FAIL reset_scan_rd1 addr %0d got %h exp %h", 7 - a, rd1_m, 16'h0000); end
    end
    re0 = 1'b0; re1 = 1'b0;
  endtask

  task automatic test_write_read();
    we = 1'b1; waddr = 3'd3; wdata = 16'hA5C3; wbe = 2'b11;
    step();
    we = 1'b0; re0 = 1'b1; ra0 = 3'd3;
    step();
    checks++; if (rd0_m !== 16'hA5C3) begin errors++; $display("FAIL wr_rd_main got %h exp %h", rd0_m, 16'hA5C3); end
    checks++; if (rd0_b0 !== 16'hA5C3) begin errors++; $display("FAIL wr_rd_nobyp got %h exp %h", rd0_b0, 16'hA5C3); end
    re0 = 1'b0;
  endtask

  task automatic test_byte_enable_hold();
    we = 1'b1; waddr = 3'd3; wdata = 16'h1234; wbe = 2'b01;
    step();
    we = 1'b0; wbe = 2'b11; re0 = 1'b1; ra0 = 3'd3;
    step();
    checks++; if (rd0_m !== 16'hA534) begin errors++; $display("FAIL byte_en got %h exp %h", rd0_m, 16'hA534); end
    re0 = 1'b0; ra0 = 3'd5;
    step();
    checks++; if (rd0_m !== 16'hA534) begin errors++; $display("FAIL hold_a got %h exp %h", rd0_m, 16'hA534); end
    ra0 = 3'd0;
    step();
    checks++; if (rd0_m !== 16'hA534) begin errors++; $display("FAIL hold_b got %h exp %h", rd0_m, 16'hA534); end
  endtask

  task automatic test_bypass();
    we = 1'b1; waddr = 3'd5; wdata = 16'hBEEF; wbe = 2'b11;
    re0 = 1'b0; re1 = 1'b1; ra1 = 3'd5;
    step();
    checks++; if (rd1_m !== 16'hBEEF) begin errors++; $display("FAIL bypass_on got %h exp %h", rd1_m, 16'hBEEF); end
    checks++; if (rd1_b0 !== 16'h0000) begin errors++; $display("FAIL bypass_off got %h exp %h", rd1_b0, 16'h0000); end
    // Partial write forwarded to both ports at once.
    we = 1'b1; waddr = 3'd5; wdata = 16'h1200; wbe = 2'b10;
    re0 = 1'b1; ra0 = 3'd5; re1 = 1'b1; ra1 = 3'd5;
    step();
    checks++; if (rd0_m !== 16'h12EF) begin errors++; $display("FAIL bypass_merge_rd0 got %h exp %h", rd0_m, 16'h12EF); end
    checks++; if (rd1_m !== 16'h12EF) begin errors++; $display("FAIL bypass_merge_rd1 got %h exp %h", rd1_m, 16'h12EF); end
    checks++; if (rd0_b0 !== 16'hBEEF) begin errors++; $display("FAIL nobyp_old_rd0 got %h exp %h", rd0_b0, 16'hBEEF); end
    checks++; if (rd1_b0 !== 16'hBEEF) begin errors++; $display("FAIL nobyp_old_rd1 got %h exp %h", rd1_b0, 16'hBEEF); end
    we = 1'b0; wbe = 2'b11;
    step();
    checks++; if (rd0_b0 !== 16'h12EF) begin errors++; $display("FAIL nobyp_late got %h exp %h", rd0_b0, 16'h12EF); end
    re0 = 1'b0; re1 = 1'b0;
  endtask

  task automatic test_clear();
    we = 1'b1; waddr = 3'd2; wdata = 16'h5555; wbe = 2'b11;
    step();
    we = 1'b0; re0 = 1'b1; ra0 = 3'd2;
    step();
    checks++; if (rd0_m !== 16'h5555) begin errors++; $display("FAIL clr_pre got %h exp %h", rd0_m, 16'h5555); end
    // Clear with a concurrent write; port 0 idle must hold, port 1 loads 0.
    clr = 1'b1; we = 1'b1; waddr = 3'd2; wdata = 16'hFFFF; wbe = 2'b11;
    re0 = 1'b0; re1 = 1'b1; ra1 = 3'd2;
    step();
    checks++; if (rd0_m !== 16'h5555) begin errors++; $display("FAIL clr_hold got %h exp %h", rd0_m, 16'h5555); end
    checks++; if (rd1_m !== 16'h0000) begin errors++; $display("FAIL clr_rd_byp got %h exp %h", rd1_m, 16'h0000); end
    checks++; if (rd1_b0 !== 16'h0000) begin errors++; $display("FAIL clr_rd_nobyp got %h exp %h", rd1_b0, 16'h0000); end
    clr = 1'b0; we = 1'b0; re0 = 1'b1; ra0 = 3'd2; re1 = 1'b1; ra1 = 3'd5;
    step();
    checks++; if (rd0_m !== 16'h0000) begin errors++; $display("FAIL clr_addr2 got %h exp %h", rd0_m, 16'h0000); end
    checks++; if (rd1_m !== 16'h0000) begin errors++; $display("FAIL clr_addr5 got %h exp %h", rd1_m, 16'h0000); end
    // Reset together with clear.
    re1 = 1'b0;
    we = 1'b1; waddr = 3'd2; wdata = 16'h1111; wbe = 2'b11;
    step();
    we = 1'b0; re0 = 1'b1; ra0 = 3'd2;
    step();
    checks++; if (rd0_m !== 16'h1111) begin errors++; $display("FAIL rstclr_pre got %h exp %h", rd0_m, 16'h1111); end
    reset = 1'b1; clr = 1'b1; we = 1'b1; waddr = 3'd2; wdata = 16'hFFFF;
    step();
    reset = 1'b0; clr = 1'b0; we = 1'b0;
    checks++; if (rd0_m !== 16'h0000) begin errors++; $display("FAIL rstclr_out got %h exp %h", rd0_m, 16'h0000); end
    step();
    checks++; if (rd0_m !== 16'h0000) begin errors++; $display("FAIL rstclr_addr2 got %h exp %h", rd0_m, 16'h0000); end
    re0 = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [15:0] dk;
    logic [15:0] dprev;
    dprev = 16'h0000;
    for (int k = 1; k <= 4; k++) begin
      dk = 16'(16'h1000 + k * 16'h0101);
      we = 1'b1; waddr = 3'(k); wdata = dk; wbe = 2'b11;
      re0 = 1'b1; ra0 = 3'(k - 1); re1 = 1'b1; ra1 = 3'(k);
      step();
      checks++; if (rd0_b0 !== dprev) begin errors++; $display("FAIL b2b_prev k%0d got %h exp %h", k, rd0_b0, dprev); end
      checks++; if (rd1_m !== dk) begin errors++; $display("FAIL b2b_byp k%0d got %h exp %h", k, rd1_m, dk); end
      checks++; if (rd1_b0 !== 16'h0000) begin errors++; $display("FAIL b2b_nobyp k%0d got %h exp %h", k, rd1_b0, 16'h0000); end
      dprev = dk;
    end
    we = 1'b0; re0 = 1'b0; re1 = 1'b0;
  endtask

  task automatic test_zero_reg();
    we = 1'b1; waddr = 3'd0; wdata = 16'h7777; wbe = 2'b11;
    re0 = 1'b1; ra0 = 3'd0;
    step();
    checks++; if (rd0_z !== 16'h0000) begin errors++; $display("FAIL zero_byp got %h exp %h", rd0_z, 16'h0000); end
    checks++; if (rd0_m !== 16'h7777) begin errors++; $display("FAIL nonzero_byp got %h exp %h", rd0_m, 16'h7777); end
    we = 1'b0;
    step();
    checks++; if (rd0_z !== 16'h0000) begin errors++; $display("FAIL zero_read got %h exp %h", rd0_z, 16'h0000); end
    checks++; if (rd0_b0 !== 16'h7777) begin errors++; $display("FAIL nonzero_read got %h exp %h", rd0_b0, 16'h7777); end
    re0 = 1'b0;
  endtask

  task automatic test_range();
    we = 1'b1; waddr = 3'd7; wdata = 16'hABCD; wbe = 2'b11;
    step();
    waddr = 3'd5; wdata = 16'h4242;
    step();
    we = 1'b0; re0 = 1'b1; ra0 = 3'd7; re1 = 1'b1; ra1 = 3'd6;
    step();
    checks++; if (rd0_d6 !== 16'h0000) begin errors++; $display("FAIL range_addr7 got %h exp %h", rd0_d6, 16'h0000); end
    checks++; if (rd1_d6 !== 16'h0000) begin errors++; $display("FAIL range_addr6 got %h exp %h", rd1_d6, 16'h0000); end
    checks++; if (rd0_m !== 16'hABCD) begin errors++; $display("FAIL inrange_addr7 got %h exp %h", rd0_m, 16'hABCD); end
    ra0 = 3'd5; ra1 = 3'd5;
    step();
    checks++; if (rd0_d6 !== 16'h4242) begin errors++; $display("FAIL same_addr_rd0 got %h exp %h", rd0_d6, 16'h4242); end
    checks++; if (rd1_d6 !== 16'h4242) begin errors++; $display("FAIL same_addr_rd1 got %h exp %h", rd1_d6, 16'h4242); end
    re0 = 1'b0; re1 = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b1; clr = 1'b0; we = 1'b0; waddr = '0; wdata = '0; wbe = '0;
    re0 = 1'b0; ra0 = '0; re1 = 1'b0; ra1 = '0;
    step();
    step();
    reset = 1'b0;

    test_reset();
    test_write_read();
    test_byte_enable_hold();
    test_bypass();
    test_clear();
    test_back_to_back();
    test_zero_reg();
    test_range();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
